// File: rtl/instruction_fetch_queue_if.sv
// Bundle of the memory-port, redirect and decode-handshake signals of the
// instruction fetch queue. The master side is the fetch queue itself; the
// slave side is the surrounding memory/execute/decode environment.
interface instruction_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_mode;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output mem_mode,
        output mem_address,
        output mem_data_in,
        input  mem_data_out,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  mem_mode,
        input  mem_address,
        input  mem_data_in,
        output mem_data_out,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: owns the PC, issues one word read per cycle to a
// memory with one cycle of read latency, and buffers the returned words with
// their PCs in a DEPTH-entry FIFO towards decode. A redirect flushes the FIFO,
// drops the read in flight and restarts fetching at the new PC.
module instruction_fetch_queue #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4,
    parameter int                PC_STEP   = 1,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic              MODE_READ = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_queue_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pend_pc_q,  pend_pc_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];

    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    demand;

    // Fixed memory-port outputs and FIFO head presentation.
    always_comb begin
        bus.mem_mode    = MODE_READ;
        bus.mem_address = fetch_pc_q;
        bus.mem_data_in = '0;
        bus.instr_valid = (count_q != '0);
        bus.instr       = data_q[rd_ptr_q];
        bus.instr_pc    = pc_q[rd_ptr_q];
    end

    // Next-state logic: issue, capture, pop and redirect flush.
    always_comb begin
        pop    = (count_q != '0) && bus.instr_ready;
        push   = inflight_q && !bus.redirect_valid;
        // Entries held plus the read in flight, less the one leaving now;
        // a new read may issue only if its response is sure to find space.
        demand = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        issue  = !bus.redirect_valid && (demand < (CNT_W+1)'(DEPTH));

        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        inflight_d = issue;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        data_d     = data_q;
        pc_d       = pc_q;

        if (issue) begin
            pend_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        end

        if (push) begin
            data_d[wr_ptr_q] = bus.mem_data_out;
            pc_d[wr_ptr_q]   = pend_pc_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Redirect outranks everything: empty the queue, forget the pending
        // response and restart at the target PC.
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: a default 32-bit instance driven
// through stream, reset, back-pressure and redirect steps, plus a 4-bit
// address instance started at PC 14 to observe PC wrap-around.
module tb_instruction_fetch_queue;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    instruction_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus_m ();
    instruction_fetch_queue_if #(.ADDR_W(4),  .DATA_W(32)) bus_w ();

    instruction_fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .PC_STEP(1),
        .RESET_PC(32'd0), .MODE_READ(1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    instruction_fetch_queue #(
        .ADDR_W(4), .DATA_W(32), .DEPTH(4), .PC_STEP(1),
        .RESET_PC(4'd14), .MODE_READ(1'b0)
    ) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: word[k] = k + 100, returned one cycle after the address.
    always @(posedge clk) begin
        bus_m.mem_data_out <= bus_m.mem_address + 32'd100;
        bus_w.mem_data_out <= {28'd0, bus_w.mem_address} + 32'd100;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 64'(bus_m.instr_valid), 64'd1);
        check({tag, "_pc"},    64'(bus_m.instr_pc),    64'(pc));
        check({tag, "_instr"}, 64'(bus_m.instr),       64'(pc + 32'd100));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        bus_m.instr_ready    = 1'b1;
        bus_m.redirect_valid = 1'b0;
        bus_m.redirect_pc    = '0;
        bus_w.instr_ready    = 1'b1;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = '0;

        // Reset state
        step(); step(); step();
        check("rst_valid",   64'(bus_m.instr_valid), 64'd0);
        check("rst_instr",   64'(bus_m.instr),       64'd0);
        check("rst_pc",      64'(bus_m.instr_pc),    64'd0);
        check("rst_mode",    64'(bus_m.mem_mode),    64'd0);
        check("rst_wdata",   64'(bus_m.mem_data_in), 64'd0);
        check("rst_addr",    64'(bus_m.mem_address), 64'd0);
        check("rst_w_addr",  64'(bus_w.mem_address), 64'd14);

        // Stream with instr_ready=1
        rst = 1'b1;
        check("c0_addr", 64'(bus_m.mem_address), 64'd0);
        step();
        check("e1_valid", 64'(bus_m.instr_valid), 64'd0);
        check("e1_addr",  64'(bus_m.mem_address), 64'd1);
        step();
        check_head("e2", 32'd0);
        check("e2_addr",  64'(bus_m.mem_address), 64'd2);
        check("w_pc0",    64'(bus_w.instr_pc), 64'd14);
        check("w_ins0",   64'(bus_w.instr),    64'd114);
        step();
        check_head("e3", 32'd1);
        check("w_pc1",    64'(bus_w.instr_pc), 64'd15);
        step();
        check_head("e4", 32'd2);
        check("w_pc2",    64'(bus_w.instr_pc), 64'd0);
        check("w_ins2",   64'(bus_w.instr),    64'd100);
        step();
        check_head("e5", 32'd3);
        check("w_pc3",    64'(bus_w.instr_pc), 64'd1);

        // Steady state: one push and one pop per cycle, occupancy constant
        for (int i = 0; i < 20; i++) begin
            step();
            check_head("steady", 32'(4 + i));
            check("steady_addr", 64'(bus_m.mem_address), 64'(6 + i));
        end

        // Asynchronous reset between clock edges
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", 64'(bus_m.instr_valid), 64'd0);
        check("arst_instr", 64'(bus_m.instr),       64'd0);
        check("arst_pc",    64'(bus_m.instr_pc),    64'd0);
        check("arst_addr",  64'(bus_m.mem_address), 64'd0);
        bus_m.instr_ready = 1'b0;
        step(); step();
        rst = 1'b1;

        // Back-pressure: queue fills, head holds, address freezes
        step();
        check("bp_e1_valid", 64'(bus_m.instr_valid), 64'd0);
        step();
        check_head("bp_first", 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_head("bp_hold", 32'd0);
        end
        check("bp_addr_frozen", 64'(bus_m.mem_address), 64'd4);

        // Release: pairs resume in order without gap or duplicate
        bus_m.instr_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check_head("bp_resume", 32'(k));
        end
        check("bp_resume_addr", 64'(bus_m.mem_address), 64'd10);

        // Redirect with three entries queued and a read in flight
        bus_m.redirect_valid = 1'b1;
        bus_m.redirect_pc    = 32'd40;
        step();
        bus_m.redirect_valid = 1'b0;
        check("rd_valid", 64'(bus_m.instr_valid), 64'd0);
        check("rd_addr",  64'(bus_m.mem_address), 64'd40);
        step();
        check("rd_e1_valid", 64'(bus_m.instr_valid), 64'd0);
        check("rd_e1_addr",  64'(bus_m.mem_address), 64'd41);
        step();
        check_head("rd_first", 32'd40);
        step();
        check_head("rd_second", 32'd41);

        // Back-to-back redirects: the later target wins
        bus_m.redirect_valid = 1'b1;
        bus_m.redirect_pc    = 32'd20;
        step();
        bus_m.redirect_pc    = 32'd60;
        step();
        bus_m.redirect_valid = 1'b0;
        check("rr_valid", 64'(bus_m.instr_valid), 64'd0);
        check("rr_addr",  64'(bus_m.mem_address), 64'd60);
        step();
        step();
        check_head("rr_first", 32'd60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
